// File: rtl/ram_sp_be_clr.sv
// ram_sp_be_clr: single-port synchronous RAM with per-byte write enables,
// a read-valid strobe, out-of-range handling and a one-word-per-cycle clear engine.
// Ports:
//   clk, reset_n    clock, synchronous active-low reset (array itself not reset)
//   cen, wen        access enable / write select
//   be[DW/8]        byte write enables
//   addr, din       word address, write data
//   clr_req         pulse to fill every word with CLR_VAL
//   dout, rvalid    registered read data, one-cycle valid strobe per read
//   busy            high while the clear engine owns the array

// One byte lane of storage; the top holds DW/8 of these side by side.
module ram_sp_be_lane #(
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

module ram_sp_be_clr #(
  parameter int            DW      = 32,
  parameter int            AW      = 5,
  parameter int            DEPTH   = 32,
  parameter logic [DW-1:0] CLR_VAL = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cen,
  input  logic            wen,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   din,
  input  logic            clr_req,
  output logic [DW-1:0]   dout,
  output logic            rvalid,
  output logic            busy
);
  localparam int NB = DW / 8;
  // One extra bit so DEPTH == 2**AW is representable without wrap.
  localparam int CW = AW + 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 in_range, acc, acc_wr, acc_rd;
  logic [AW-1:0]        waddr;
  logic [NB-1:0][7:0]   rd_word;

  assign busy     = (state_q == CLEAR);
  assign in_range = ({1'b0, addr} < CW'(DEPTH));
  // A clear request in the same cycle as an access wins; the access is dropped.
  assign acc      = !busy && cen && !clr_req;
  assign acc_wr   = acc && wen && in_range;
  assign acc_rd   = acc && !wen;
  assign waddr    = busy ? cnt_q[AW-1:0] : addr;

  generate
    for (genvar i = 0; i < NB; i++) begin : g_lane
      ram_sp_be_lane #(.AW(AW), .DEPTH(DEPTH)) u_lane (
        .clk   (clk),
        // Writes are suppressed while reset is held so a reset landing mid-clear
        // leaves the not-yet-cleared words untouched.
        .we    (reset_n && (busy || (acc_wr && be[i]))),
        .waddr (waddr),
        .wdata (busy ? CLR_VAL[8*i +: 8] : din[8*i +: 8]),
        .raddr (addr),
        .rdata (rd_word[i])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:
        if (clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout    <= '0;
      rvalid  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rvalid  <= acc_rd;
      if (acc_rd) dout <= in_range ? rd_word : '0;
    end
  end
endmodule
